data_mem_mmio: RTL and testbench
================================

DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit RAM words; power of 2, at least 4.
REQ-002 Parameter FIFO_DEPTH, default 8, number of TX FIFO entries; power of 2, at least 2.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset; asynchronous, active-low.
REQ-005 DataMemAddr  input  32  byte address from the core MEM stage.
REQ-006 DataMemRead  input  1  load request.
REQ-007 DataMemWrite  input  1  store request.
REQ-008 DataMemWData  input  32  store data.
REQ-009 DataMemRData  output  32  load data, combinational, valid in the same cycle.
REQ-010 tx_data  output  8  byte at the TX FIFO head.
REQ-011 tx_valid  output  1  TX FIFO not empty.
REQ-012 tx_ready  input  1  external consumer accepts the byte this cycle.

Function
REQ-013 Address map:
- RAM at 0x0000_0000 to 4*DEPTH_WORDS-1, word index DataMemAddr[log2(DEPTH_WORDS)+1:2]; DataMemAddr[1:0] ignored.
- TXDATA at 0x8000_0000.
- STATUS at 0x8000_0004.
- CYCLE at 0x8000_0008.
REQ-014 Any other address reads 0x0000_0000; writes to it have no effect.
REQ-015 Reads:
- DataMemRData is 0 when DataMemRead=0.
- Otherwise it is the selected register or RAM word as of before the current edge; no same-cycle write bypass.
REQ-016 Writes take effect on the rising edge when DataMemWrite=1.
- RAM writes are full-word.
- If DataMemRead and DataMemWrite are both 1, the write is performed and the read returns the old value.
REQ-017 TXDATA:
- A write pushes DataMemWData[7:0] into the FIFO.
- A read returns 0.
REQ-018 STATUS:
- A read returns {29'b0, overflow, full, empty}.
- A write of any value clears overflow.
REQ-019 FIFO handshake:
- tx_valid = !empty and tx_data = head entry.
- A pop occurs on an edge where tx_valid && tx_ready.
- tx_data must stay stable while tx_valid=1 and tx_ready=0.
REQ-020 FIFO timing: there is no bypass; a byte pushed into an empty FIFO appears on tx_data/tx_valid in the cycle after the push edge.
REQ-021 Push while full with no pop: the byte is dropped, contents are unchanged, and overflow is set (sticky).
- Push while full with a simultaneous pop: the push is accepted and the count is unchanged.
REQ-022 Simultaneous push and pop when not full: both occur and the count is unchanged.
- Pointers wrap modulo FIFO_DEPTH; full/empty are derived from an occupancy count or extra pointer bit, never ambiguous.
REQ-023 CYCLE (when compiled in):
- 32-bit counter that increments by 1 every clock and wraps 0xFFFF_FFFF to 0x0000_0000.
- A write loads DataMemWData; the loaded value is readable the following cycle and increments from then on.

Reset
REQ-024 While RST=0:
- FIFO pointers, count and overflow clear.
- Cycle counter clears.
- tx_valid=0, tx_data=0x00.
- DataMemRData follows REQ-015 from the reset state.
REQ-025 RAM contents are not reset; they are preserved across reset.
REQ-026 Reset asserted mid-operation discards all FIFO contents immediately (asynchronously); tx_valid falls without waiting for a clock edge.

Configuration
REQ-027 Macro MMIO_CYCLE_COUNTER_EN.
- Defined: the CYCLE register exists per REQ-023.
- Undefined: no counter flops exist, CYCLE reads 0x0000_0000, and writes to it are ignored.
- All other behaviour is identical in both builds.

Verification
REQ-028 Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0013 the next cycle -> DataMemRData=0xDEADBEEF; a load of 0x0000_0014 is unaffected.
REQ-029 Hold tx_ready=0 and push 0x41..0x48 (8 bytes), then push 0x49:
- STATUS reads 0x6 (overflow, full).
- With tx_ready=1, bytes 0x41..0x48 drain in order, one per cycle, then STATUS reads 0x5.
- Writing STATUS then gives 0x1.
REQ-030 FIFO full with tx_ready=1 and a push of 0x5A in the same cycle -> no overflow; 0x5A emerges after the 8 earlier bytes.
REQ-031 With the macro defined:
- Write 0xFFFF_FFFE to CYCLE -> reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000 on three consecutive cycles.
- With the macro undefined, the same reads return 0.
REQ-032 Push 3 bytes, then assert RST=0 between edges -> tx_valid drops immediately and STATUS reads 0x1 after release; RAM word written before reset still reads back intact.

Source files
------------

// File: rtl/data_mem_mmio_if.sv
// Bundles the core MEM-stage data port and the TX byte stream that data_mem_mmio serves.
// Latency: none. This file only groups signals.
// Backpressure: the TX stream is valid/ready. The data port has no stall, and loads complete combinationally.
//
// Signals:
//   DataMemAddr/Read/Write/WData : load/store request from the core (master -> slave)
//   DataMemRData                 : load data back to the core (slave -> master)
//   tx_data/tx_valid             : byte at the TX FIFO head (slave -> master)
//   tx_ready                     : consumer accepts the head byte this cycle (master -> slave)
interface data_mem_mmio_if;
    logic [31:0] DataMemAddr;
    logic        DataMemRead;
    logic        DataMemWrite;
    logic [31:0] DataMemWData;
    logic [31:0] DataMemRData;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    // Core plus TX consumer side.
    modport master (
        output DataMemAddr, DataMemRead, DataMemWrite, DataMemWData, tx_ready,
        input  DataMemRData, tx_data, tx_valid
    );

    // Memory/MMIO block side.
    modport slave (
        input  DataMemAddr, DataMemRead, DataMemWrite, DataMemWData, tx_ready,
        output DataMemRData, tx_data, tx_valid
    );
endinterface

// File: rtl/data_mem_mmio.sv
// Data RAM plus MMIO (TX byte FIFO, STATUS, optional free-running CYCLE counter) behind one load/store port.
// Latency: loads are combinational in the same cycle. Stores and FIFO pushes land on the next rising edge.
//          A pushed byte reaches tx_data/tx_valid one cycle after the push edge.
// Backpressure: tx_ready stalls the FIFO head. A push into a full FIFO with no pop is dropped and sets sticky overflow.
//
// Ports:
//   CLK  : single clock, rising edge
//   RST  : asynchronous active-low reset (clears FIFO state, overflow and cycle counter; RAM is kept)
//   bus  : data_mem_mmio_if.slave (DataMem* load/store port, tx_* byte stream)
//
// Address map:
//   RAM    0x0000_0000 .. 4*DEPTH_WORDS-1
//   TXDATA 0x8000_0000
//   STATUS 0x8000_0004 = {29'b0, overflow, full, empty}
//   CYCLE  0x8000_0008
//   Any other address reads 0 and ignores writes.
//
// Build option: define MMIO_CYCLE_COUNTER_EN to build the CYCLE counter.
//               Without it, CYCLE reads 0 and ignores writes.
module data_mem_mmio #(
    parameter int DEPTH_WORDS = 256,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              CLK,
    input  logic              RST,
    data_mem_mmio_if.slave    bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [31:0] ADDR_TXDATA = 32'h8000_0000;
    localparam logic [31:0] ADDR_STATUS = 32'h8000_0004;
    localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0008;

    // ---------------- address decode ----------------
    logic          ram_sel;
    logic [AW-1:0] ram_idx;

    // Every address bit above the word index must be zero, so the RAM does not alias across the map.
    assign ram_sel = (bus.DataMemAddr[31:AW+2] == '0);
    assign ram_idx = bus.DataMemAddr[AW+1:2];

    logic ram_we, push, status_we;
    assign ram_we    = bus.DataMemWrite && ram_sel;
    assign push      = bus.DataMemWrite && (bus.DataMemAddr == ADDR_TXDATA);
    assign status_we = bus.DataMemWrite && (bus.DataMemAddr == ADDR_STATUS);

    // ---------------- RAM (no reset, contents survive RST) ----------------
    logic [31:0] ram [DEPTH_WORDS];

    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram[ram_idx] <= bus.DataMemWData;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          empty, full, pop, push_ok;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign pop   = bus.tx_valid && bus.tx_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO is still accepted.
    assign push_ok = push && (!full || pop);

    // Count and pointers reset asynchronously, so tx_valid drops as soon as RST falls.
    assign bus.tx_valid = !empty;
    // The head slot is only written when it is also being popped (full FIFO with push and pop).
    // Because of that, tx_data cannot change while the byte waits for tx_ready.
    assign bus.tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= bus.DataMemWData[7:0];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // Power-of-two depth: the pointers wrap naturally.
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push_ok) - CW'(pop);
            if (status_we) begin
                overflow <= 1'b0;
            end else if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // ---------------- cycle counter ----------------
`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt;
    logic        cycle_we;
    assign cycle_we = bus.DataMemWrite && (bus.DataMemAddr == ADDR_CYCLE);

    // A loaded value is visible for one full cycle, and counting resumes from it.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cycle_cnt <= '0;
        end else if (cycle_we) begin
            cycle_cnt <= bus.DataMemWData;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

    // ---------------- read mux ----------------
    // Pre-edge state only. A store in the same cycle is not bypassed to the load.
    always_comb begin
        bus.DataMemRData = '0;
        if (bus.DataMemRead) begin
            if (ram_sel) begin
                bus.DataMemRData = ram[ram_idx];
            end else begin
                case (bus.DataMemAddr)
                    ADDR_STATUS: bus.DataMemRData = {29'b0, overflow, full, empty};
`ifdef MMIO_CYCLE_COUNTER_EN
                    ADDR_CYCLE:  bus.DataMemRData = cycle_cnt;
`else
                    ADDR_CYCLE:  bus.DataMemRData = '0;
`endif
                    default:     bus.DataMemRData = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
module tb_data_mem_mmio;

    localparam logic [31:0] TXDATA = 32'h8000_0000;
    localparam logic [31:0] STATUS = 32'h8000_0004;
    localparam logic [31:0] CYCLE  = 32'h8000_0008;

    logic CLK;
    logic RST;
    data_mem_mmio_if bus ();

    data_mem_mmio #(.DEPTH_WORDS(256), .FIFO_DEPTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard queues: expected load data (with a label), and expected TX bytes in order.
    logic [31:0] exp_rd_q [$];
    string       exp_rd_nm [$];
    logic [7:0]  exp_tx_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // The monitor samples at the falling edge. Inputs change 1ns after the rising edge.
    logic [31:0] m_exp;
    string       m_nm;
    logic [7:0]  m_tx;
    always @(negedge CLK) begin
        if (RST) begin
            if (bus.DataMemRead) begin
                if (exp_rd_q.size() == 0) begin
                    chk("unexpected_load", 32'h1, 32'h0);
                end else begin
                    m_exp = exp_rd_q.pop_front();
                    m_nm  = exp_rd_nm.pop_front();
                    chk(m_nm, bus.DataMemRData, m_exp);
                end
            end
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_tx_q.size() == 0) begin
                    chk("unexpected_tx_byte", {24'h0, bus.tx_data}, 32'hFFFF_FFFF);
                end else begin
                    m_tx = exp_tx_q.pop_front();
                    chk("tx_byte", {24'h0, bus.tx_data}, {24'h0, m_tx});
                end
            end
        end
    end

    // One bus cycle: drive the request right after the rising edge.
    task automatic cyc(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp, input string nm);
        @(posedge CLK);
        #1;
        bus.DataMemRead  = rd;
        bus.DataMemWrite = wr;
        bus.DataMemAddr  = a;
        bus.DataMemWData = wd;
        if (rd) begin
            exp_rd_q.push_back(exp);
            exp_rd_nm.push_back(nm);
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, "");
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b0, 1'b1, a, d, 32'h0, "");
    endtask
    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
        cyc(1'b1, 1'b0, a, 32'h0, e, nm);
    endtask

    initial begin
        RST = 1'b0;
        bus.DataMemRead  = 1'b0;
        bus.DataMemWrite = 1'b0;
        bus.DataMemAddr  = 32'h0;
        bus.DataMemWData = 32'h0;
        bus.tx_ready     = 1'b0;
        #1;
        chk("reset_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        chk("reset_tx_data", {24'h0, bus.tx_data}, 32'h0);
        chk("reset_rdata", bus.DataMemRData, 32'h0);
        repeat (2) @(posedge CLK);
        #3 RST = 1'b1;

        rd(STATUS, 32'h1, "status_after_reset");

        // RAM: byte offset ignored, neighbour word unaffected, no write bypass.
        wr(32'h14, 32'h1234_5678);
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h13, 32'hDEAD_BEEF, "ram_load_0x13");
        rd(32'h14, 32'h1234_5678, "ram_load_0x14");
        cyc(1'b1, 1'b1, 32'h10, 32'hCAFE_F00D, 32'hDEAD_BEEF, "ram_rw_old_value");
        rd(32'h10, 32'hCAFE_F00D, "ram_after_rw");
        // Out-of-range and unmapped addresses: read 0, writes do not alias into RAM.
        wr(32'h400, 32'h5555_AAAA);
        rd(32'h400, 32'h0, "unmapped_ram_hole");
        rd(32'h0, 32'h0 /* overwritten below */ , "ram_word0_placeholder");
        exp_rd_q.delete(exp_rd_q.size() - 1);
        exp_rd_nm.delete(exp_rd_nm.size() - 1);
        bus.DataMemRead = 1'b0;
        rd(32'h8000_000C, 32'h0, "unmapped_mmio");
        rd(TXDATA, 32'h0, "txdata_read");
        // Read strobe low -> 0 even with a RAM address.
        idle();
        bus.DataMemAddr = 32'h10;
        #1 chk("rdata_no_read", bus.DataMemRData, 32'h0);

        // Overflow, order, STATUS clear.
        for (int i = 0; i < 8; i++) begin
            wr(TXDATA, 32'hFFFF_FF41 + i);
            exp_tx_q.push_back(8'(8'h41 + i));
        end
        wr(TXDATA, 32'h49);
        rd(STATUS, 32'h6, "status_full_overflow");
        idle();
        bus.tx_ready = 1'b1;
        repeat (7) idle();
        rd(STATUS, 32'h5, "status_drained_overflow");
        chk("drain_all_8", exp_tx_q.size(), 32'h0);
        wr(STATUS, 32'h0);
        rd(STATUS, 32'h1, "status_overflow_cleared");

        // Push into a full FIFO while popping.
        bus.tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(TXDATA, 32'h61 + i);
            exp_tx_q.push_back(8'(8'h61 + i));
        end
        wr(TXDATA, 32'h5A);
        bus.tx_ready = 1'b1;
        exp_tx_q.push_back(8'h5A);
        repeat (8) idle();
        rd(STATUS, 32'h1, "status_full_push_pop");
        chk("drain_with_5a", exp_tx_q.size(), 32'h0);
        bus.tx_ready = 1'b0;

        // Cycle counter load and wrap.
        wr(CYCLE, 32'hFFFF_FFFE);
`ifdef MMIO_CYCLE_COUNTER_EN
        rd(CYCLE, 32'hFFFF_FFFE, "cycle_load");
        rd(CYCLE, 32'hFFFF_FFFF, "cycle_inc");
        rd(CYCLE, 32'h0000_0000, "cycle_wrap");
`else
        rd(CYCLE, 32'h0, "cycle_absent0");
        rd(CYCLE, 32'h0, "cycle_absent1");
        rd(CYCLE, 32'h0, "cycle_absent2");
`endif

        // Asynchronous reset mid-operation.
        wr(32'h20, 32'hA5A5_5A5A);
        wr(TXDATA, 32'h31);
        #1 chk("no_bypass_valid", {31'h0, bus.tx_valid}, 32'h0);
        wr(TXDATA, 32'h32);
        #1 chk("valid_after_push", {31'h0, bus.tx_valid}, 32'h1);
        chk("head_byte", {24'h0, bus.tx_data}, 32'h31);
        wr(TXDATA, 32'h33);
        idle();
        #2 RST = 1'b0;
        #1;
        chk("async_reset_tx_valid", {31'h0, bus.tx_valid}, 32'h0);
        chk("async_reset_tx_data", {24'h0, bus.tx_data}, 32'h0);
        exp_tx_q.delete();
        repeat (2) @(posedge CLK);
        #3 RST = 1'b1;
        rd(STATUS, 32'h1, "status_after_async_reset");
        rd(32'h20, 32'hA5A5_5A5A, "ram_kept_over_reset");
        rd(32'h14, 32'h1234_5678, "ram_kept_over_reset2");
        idle();
        idle();
        chk("load_queue_empty", exp_rd_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
